mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3b_types.sv | 29 ++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/lc3b_types.sv
// ----------------------------------------------------------------------------
// lc3b_types
// Shared LC-3b type definitions used by the memory-side blocks.
//   lc3b_word       16-bit data/address word
//   lc3b_mem_wmask  2-bit byte write mask (bit 1 = high byte, bit 0 = low byte)
//   arb_state_t     memory arbiter FSM state
//   streak_t        4-bit saturating count of consecutive D grants
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef logic [3:0] streak_t;

   // Increment that sticks at the top of the 4-bit range instead of wrapping.
   function automatic streak_t streak_inc(input streak_t s);
      return (s == 4'hF) ? s : s + 4'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between an instruction-fetch requester (I) and a
// data requester (D). D has priority, but after STARVE_LIMIT consecutive D
// grants taken while I was waiting, the next grant goes to I. Every grant is
// followed by one IDLE cycle once the memory responds.
//
// Parameters
//   STARVE_LIMIT  max consecutive D grants while i_read waits (1..15)
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   i_read, i_address              fetch read request (held until i_resp)
//   i_rdata, i_resp                fetch read data, completion pulse
//   d_read, d_write, d_wmask,
//   d_address, d_wdata             data request (held until d_resp)
//   d_rdata, d_resp                data read data, completion pulse
//   mem_read, mem_write, mem_wmask,
//   mem_address, mem_wdata         shared memory command (all registered)
//   mem_rdata, mem_resp            shared memory read data, completion
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_arbiter
   import lc3b_types::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          i_read,
   input  lc3b_word      i_address,
   output lc3b_word      i_rdata,
   output logic          i_resp,

   input  logic          d_read,
   input  logic          d_write,
   input  lc3b_mem_wmask d_wmask,
   input  lc3b_word      d_address,
   input  lc3b_word      d_wdata,
   output lc3b_word      d_rdata,
   output logic          d_resp,

   output logic          mem_read,
   output logic          mem_write,
   output lc3b_mem_wmask mem_wmask,
   output lc3b_word      mem_address,
   output lc3b_word      mem_wdata,
   input  lc3b_word      mem_rdata,
   input  logic          mem_resp
);

   localparam streak_t LIMIT = streak_t'(STARVE_LIMIT);

   arb_state_t state;
   streak_t    streak;

   logic d_req;
   logic d_wins;

   assign d_req  = d_read | d_write;
   // D wins unless it has already taken LIMIT grants in a row while I waited.
   assign d_wins = d_req && ((streak < LIMIT) || !i_read);

   // The mem_* outputs are the latched command itself: they only change on a
   // grant (load) or on the response edge (strobes drop), so the memory sees
   // a stable command for the whole transaction even if the requester moves.
   // NOTE: all state here is written with non-blocking assignments so every
   // register samples the pre-edge values of the others; mixing in blocking
   // assignments would make the result depend on statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         streak      <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_wmask   <= '0;
         mem_address <= '0;
         mem_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (d_wins) begin
                  state       <= SERVE_D;
                  mem_address <= d_address;
                  mem_wdata   <= d_wdata;
                  mem_wmask   <= d_wmask;
                  // A request with both kinds set is treated as a write.
                  mem_write   <= d_write;
                  mem_read    <= ~d_write;
                  streak      <= i_read ? streak_inc(streak) : '0;
               end else if (i_read) begin
                  state       <= SERVE_I;
                  mem_address <= i_address;
                  mem_wdata   <= '0;
                  mem_wmask   <= '0;
                  mem_write   <= 1'b0;
                  mem_read    <= 1'b1;
                  streak      <= '0;
               end
            end

            SERVE_I, SERVE_D: begin
               if (mem_resp) begin
                  state     <= IDLE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
            end
         endcase
      end
   end

   // Responses are forwarded combinationally in the mem_resp cycle; a
   // response arriving while IDLE matches neither state and is dropped.
   assign i_resp  = mem_resp & (state == SERVE_I);
   assign d_resp  = mem_resp & (state == SERVE_D);

   // Read data goes to both sides unqualified; each consumer uses its resp.
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

endmodule
